toy_cpu_gen2: RTL and testbench
===============================

# toy_cpu_gen2

Parametrised second-generation toy accumulator processor. Fetches one-hot opcodes and operand words from an external synchronous memory over a shared `ADDR`/`D_IN`/`D_OUT` bus, and executes them against an accumulator. Compared with the fixed 8-bit, 6-state part, it adds:
- generic data and address widths;
- an add path with zero and carry flags;
- branches and a halt state.

It sits between the lab memory model and the board-level status LEDs, which show `STATE`.

## Interface
- `DATA_W`, 8, data/instruction word width; must be ≥ 8.
- `ADDR_W`, 8, address width; operand words supply addresses as their low `ADDR_W` bits.
- `RESET_PC`, 0, PC value after reset.
- `CLK`  in  1  rising-edge clock.
- `RESET`  in  1  synchronous, active-low reset (sampled on `CLK` rising edge; 0 = reset).
- `D_IN`  in  `DATA_W`  memory read data; valid in the cycle after a read request.
- `ADDR`  out  `ADDR_W`  memory address.
- `D_OUT`  out  `DATA_W`  memory write data.
- `MEM_EN`  out  1  memory access request this cycle.
- `RORW`  out  1  1 = read, 0 = write; meaningful only while `MEM_EN`=1.
- `STATE`  out  8  one-hot current state, bit order FETCH..HALT as listed below.
- `ZERO`  out  1  accumulator-zero flag.
- `CARRY`  out  1  carry out of the last ADD.
- `HALTED`  out  1  high while in HALT.

## Operation
- Registers:
  - PC: `ADDR_W` bits.
  - IR: opcode, low 8 bits of the instruction word.
  - OPR: `DATA_W` bits.
  - ACC: `DATA_W` bits.
- Flags: Z and C.
- Opcodes (low 8 bits): 0x01 LDI, 0x02 LDA, 0x04 ADD, 0x08 STA, 0x10 JMP, 0x20 JZ, 0x80 HLT.
  - 0x00 and any non-listed value are NOP: no operand fetch, no state change beyond PC+1.
- One state per clock:
  - FETCH: `ADDR`=PC, `MEM_EN`=1, `RORW`=1 → DECODE.
  - DECODE: IR←`D_IN`, PC←PC+1. NOP → FETCH; HLT → HALT; else → OPFETCH.
  - OPFETCH: `ADDR`=PC, read → OPLATCH.
  - OPLATCH: OPR←`D_IN`, PC←PC+1, then by opcode:
    - LDI: ACC←`D_IN`, Z updated → FETCH.
    - JMP: PC←`D_IN`[ADDR_W-1:0] → FETCH.
    - JZ: PC←`D_IN` if Z else PC+1 → FETCH.
    - LDA/ADD → MEMRD.
    - STA → WRITE.
  - MEMRD: `ADDR`=OPR, read → EXEC.
  - EXEC:
    - LDA: ACC←`D_IN`.
    - ADD: {C,ACC}←ACC+`D_IN`, as (`DATA_W`+1)-bit sum.
    - Z←(new ACC==0) in both cases → FETCH.
  - WRITE: `ADDR`=OPR, `D_OUT`=ACC, `MEM_EN`=1, `RORW`=0 → FETCH.
  - HALT: absorbing state; only reset leaves it.
- Flag rules: C changes only on ADD. Z changes only on LDI, LDA and ADD.
- PC arithmetic wraps modulo 2^`ADDR_W`; an instruction at the top address fetches its operand from address 0.
- Reset values: PC=`RESET_PC`, ACC=0, IR=0, OPR=0, Z=1, C=0, state=FETCH.
  - Outputs in reset: `STATE`=8'b0000_0001, `MEM_EN`=0, `RORW`=1, `ADDR`=`RESET_PC`, `D_OUT`=0, `HALTED`=0.
- `RESET` low mid-instruction aborts it with no partial write; a WRITE cycle coinciding with reset low drives `MEM_EN`=0.

## Timing
- `MEM_EN` is combinational from state and is high only in FETCH, OPFETCH, MEMRD and WRITE.
- `D_IN` is sampled on the clock edge ending the cycle after the request.
- Latencies in clocks: NOP 2, HLT 2, LDI/JMP/JZ 4, STA 5, LDA/ADD 6.
- `ADDR` holds its last value in non-memory states.
- `D_OUT` is ACC in WRITE and 0 otherwise.
- The first FETCH occurs in the cycle after `RESET` is sampled high.

## Configuration
- `TOY_CPU_BRANCH_EN` defined: JMP and JZ behave as above.
- Undefined: 0x10 and 0x20 decode as NOP (2 clocks, no operand fetch), and no branch logic is synthesised.

## Structure
- `toy_cpu_pkg` holds:
  - opcode constants;
  - the state enum and one-hot index constants;
  - `RORW` read/write constants.
- One sub-module, `toy_cpu_alu`: a combinational `DATA_W`-bit adder/pass unit producing result, carry and zero, instantiated once.

## Test plan
- Reset and LDI: hold `RESET`=0 for 2 clocks, release; program 0x01,0xAA,0x80 → ACC=0xAA, Z=0, `HALTED`=1 at cycle 6; `STATE` one-hot every cycle.
- ADD with carry: mem[0x10]=0x01; program LDI 0xFF, ADD 0x10 → ACC=0x00, C=1, Z=1.
- STA write cycle: LDI 0x5C, STA 0x20 → one cycle with `MEM_EN`=1, `RORW`=0, `ADDR`=0x20, `D_OUT`=0x5C.
- Branch:
  - Z=1 with JZ 0x40 → next FETCH `ADDR`=0x40.
  - Z=0 → falls through to PC+2.
  - Macro undefined → JZ takes 2 clocks, no operand read.
- Wrap and reset abort:
  - LDI placed at 0xFF → operand read from 0x00.
  - `RESET`=0 asserted in OPLATCH of an STA → no write cycle; PC=`RESET_PC` next cycle.
- Width sweep: `DATA_W`=16, `ADDR_W`=10 → ADD 0xFFFF+0x0002 gives ACC=0x0001, C=1.

Source files
------------

// File: rtl/toy_cpu_pkg.sv
// toy_cpu_pkg: shared definitions for the toy_cpu_gen2 accumulator processor.
//   - one-hot opcode constants (low 8 bits of the instruction word)
//   - FSM state enum, STATE bit index constants and the state -> one-hot helper
//   - RORW read/write encodings
//   - needs_operand(): which opcodes carry an operand word
// Optional feature macro: TOY_CPU_BRANCH_EN (JMP/JZ fetch an operand only when defined).
package toy_cpu_pkg;

    localparam logic [7:0] OpNop = 8'h00;
    localparam logic [7:0] OpLdi = 8'h01;
    localparam logic [7:0] OpLda = 8'h02;
    localparam logic [7:0] OpAdd = 8'h04;
    localparam logic [7:0] OpSta = 8'h08;
    localparam logic [7:0] OpJmp = 8'h10;
    localparam logic [7:0] OpJz  = 8'h20;
    localparam logic [7:0] OpHlt = 8'h80;

    // Encoding value equals the STATE bit position.
    typedef enum logic [2:0] {
        StFetch   = 3'd0,
        StDecode  = 3'd1,
        StOpFetch = 3'd2,
        StOpLatch = 3'd3,
        StMemRd   = 3'd4,
        StExec    = 3'd5,
        StWrite   = 3'd6,
        StHalt    = 3'd7
    } state_e;

    localparam int unsigned IdxFetch   = 0;
    localparam int unsigned IdxDecode  = 1;
    localparam int unsigned IdxOpFetch = 2;
    localparam int unsigned IdxOpLatch = 3;
    localparam int unsigned IdxMemRd   = 4;
    localparam int unsigned IdxExec    = 5;
    localparam int unsigned IdxWrite   = 6;
    localparam int unsigned IdxHalt    = 7;

    localparam logic RorwRead  = 1'b1;
    localparam logic RorwWrite = 1'b0;

    function automatic logic [7:0] state_onehot(state_e s);
        return 8'b1 << s;
    endfunction

    // Opcodes not listed here (other than HLT) execute as 2-cycle NOPs.
    function automatic logic needs_operand(logic [7:0] op);
        case (op)
            OpLdi, OpLda, OpAdd, OpSta: return 1'b1;
`ifdef TOY_CPU_BRANCH_EN
            OpJmp, OpJz:                return 1'b1;
`endif
            default:                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/toy_cpu_gen2_if.sv
// toy_cpu_gen2_if: shared memory bus between the CPU (master) and the memory (slave).
//   ADDR   [ADDR_W] address            D_OUT [DATA_W] write data
//   MEM_EN          access request      RORW           1 = read, 0 = write
//   D_IN   [DATA_W] read data, valid the cycle after a read request
interface toy_cpu_gen2_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
);
    logic [ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0] D_IN;
    logic [DATA_W-1:0] D_OUT;
    logic              MEM_EN;
    logic              RORW;

    modport master (output ADDR, output D_OUT, output MEM_EN, output RORW, input D_IN);
    modport slave  (input ADDR, input D_OUT, input MEM_EN, input RORW, output D_IN);
endinterface

// File: rtl/toy_cpu_alu.sv
// toy_cpu_alu: combinational DATA_W-bit adder / pass unit.
//   a_i, b_i  operands (a = accumulator, b = memory data)
//   add_i     1: result = a + b with carry out; 0: result = b, carry 0
//   result_o, carry_o, zero_o (result == 0)
module toy_cpu_alu #(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              add_i,
    output logic [DATA_W-1:0] result_o,
    output logic              carry_o,
    output logic              zero_o
);
    logic [DATA_W:0] sum;

    always_comb begin
        sum = {1'b0, a_i} + {1'b0, b_i};
        if (add_i) begin
            {carry_o, result_o} = sum;
        end else begin
            {carry_o, result_o} = {1'b0, b_i};
        end
        zero_o = (result_o == '0);
    end
endmodule

// File: rtl/toy_cpu_gen2.sv
// toy_cpu_gen2: parametrised accumulator processor fetching one-hot opcodes over a shared bus.
//   CLK     rising-edge clock
//   RESET   synchronous active-low reset
//   bus     toy_cpu_gen2_if.master (ADDR, D_IN, D_OUT, MEM_EN, RORW)
//   STATE   one-hot state, bit 0 FETCH .. bit 7 HALT
//   ZERO    accumulator-zero flag, CARRY carry of the last ADD, HALTED high in HALT
// Optional feature macro: TOY_CPU_BRANCH_EN enables JMP/JZ; otherwise they are NOPs.
module toy_cpu_gen2
    import toy_cpu_pkg::*;
#(
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    toy_cpu_gen2_if.master        bus,
    output logic [7:0]            STATE,
    output logic                  ZERO,
    output logic                  CARRY,
    output logic                  HALTED
);
    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        ir_q;
    logic [DATA_W-1:0] opr_q;
    logic [DATA_W-1:0] acc_q;
    logic              z_q, c_q;
    // Low for the first cycle after reset is released, so the first FETCH
    // starts only after the reset edge has seen RESET high.
    logic              run_q;

    logic [DATA_W-1:0] alu_res;
    logic              alu_carry, alu_zero, alu_add;
    logic              mem_en, rorw;
    logic [DATA_W-1:0] d_out;
    logic [7:0]        state_oh;

    // Only the low ADDR_W bits of OPR form an address.
    logic unused_opr;
    assign unused_opr = ^(opr_q >> ADDR_W);

    assign alu_add = (state_q == StExec) && (ir_q == OpAdd);

    toy_cpu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a_i      (acc_q),
        .b_i      (bus.D_IN),
        .add_i    (alu_add),
        .result_o (alu_res),
        .carry_o  (alu_carry),
        .zero_o   (alu_zero)
    );

    always_comb begin
        mem_en   = 1'b0;
        rorw     = RorwRead;
        addr_d   = addr_q;
        d_out    = '0;
        state_oh = state_onehot(state_q);
        unique case (state_q)
            StFetch, StOpFetch: begin
                mem_en = 1'b1;
                addr_d = pc_q;
            end
            StMemRd: begin
                mem_en = 1'b1;
                addr_d = opr_q[ADDR_W-1:0];
            end
            StWrite: begin
                mem_en = 1'b1;
                rorw   = RorwWrite;
                addr_d = opr_q[ADDR_W-1:0];
                d_out  = acc_q;
            end
            default: ;
        endcase
        // RESET low wins immediately so a WRITE cycle in reset never reaches memory.
        if (!RESET || !run_q) begin
            mem_en   = 1'b0;
            rorw     = RorwRead;
            addr_d   = RESET_PC;
            d_out    = '0;
            state_oh = state_onehot(StFetch);
        end
    end

    assign bus.MEM_EN = mem_en;
    assign bus.RORW   = rorw;
    assign bus.ADDR   = addr_d;
    assign bus.D_OUT  = d_out;
    assign STATE      = state_oh;
    assign HALTED     = state_oh[IdxHalt];
    assign ZERO       = z_q;
    assign CARRY      = c_q;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            ir_q    <= '0;
            opr_q   <= '0;
            acc_q   <= '0;
            z_q     <= 1'b1;
            c_q     <= 1'b0;
            run_q   <= 1'b0;
        end else if (!run_q) begin
            run_q <= 1'b1;
        end else begin
            addr_q <= addr_d;
            unique case (state_q)
                StFetch: state_q <= StDecode;
                StDecode: begin
                    ir_q <= bus.D_IN[7:0];
                    pc_q <= pc_q + ADDR_W'(1);
                    if (bus.D_IN[7:0] == OpHlt) begin
                        state_q <= StHalt;
                    end else if (needs_operand(bus.D_IN[7:0])) begin
                        state_q <= StOpFetch;
                    end else begin
                        state_q <= StFetch;
                    end
                end
                StOpFetch: state_q <= StOpLatch;
                StOpLatch: begin
                    opr_q   <= bus.D_IN;
                    pc_q    <= pc_q + ADDR_W'(1);
                    state_q <= StFetch;
                    case (ir_q)
                        OpLdi: begin
                            acc_q <= alu_res;
                            z_q   <= alu_zero;
                        end
`ifdef TOY_CPU_BRANCH_EN
                        OpJmp: pc_q <= bus.D_IN[ADDR_W-1:0];
                        OpJz: begin
                            if (z_q) begin
                                pc_q <= bus.D_IN[ADDR_W-1:0];
                            end
                        end
`endif
                        OpLda, OpAdd: state_q <= StMemRd;
                        OpSta:        state_q <= StWrite;
                        default: ;
                    endcase
                end
                StMemRd: state_q <= StExec;
                StExec: begin
                    acc_q   <= alu_res;
                    z_q     <= alu_zero;
                    if (ir_q == OpAdd) begin
                        c_q <= alu_carry;
                    end
                    state_q <= StFetch;
                end
                StWrite: state_q <= StFetch;
                StHalt:  state_q <= StHalt;
                default: state_q <= StFetch;
            endcase
        end
    end
endmodule

// File: tb/tb_toy_cpu_gen2.sv
// tb_toy_cpu_gen2: self-checking bench for toy_cpu_gen2.
// An 8-bit instance (RESET_PC = 0xFF, so every program wraps) is checked cycle by cycle
// against an instruction-level model; a 16/10-bit instance runs one ADD program.
// Honours TOY_CPU_BRANCH_EN the same way as the design.
module tb_toy_cpu_gen2;
    localparam logic [7:0] RstPc8 = 8'hFF;
`ifdef TOY_CPU_BRANCH_EN
    localparam bit BranchEn = 1'b1;
`else
    localparam bit BranchEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic load;
    logic cmp_en;
    always #5 clk = ~clk;

    toy_cpu_gen2_if #(.DATA_W(8),  .ADDR_W(8))  bus8 ();
    toy_cpu_gen2_if #(.DATA_W(16), .ADDR_W(10)) busw ();

    logic [7:0] state8, statew;
    logic       zero8, carry8, halted8, zerow, carryw, haltedw;

    toy_cpu_gen2 #(.DATA_W(8), .ADDR_W(8), .RESET_PC(RstPc8)) dut8 (
        .CLK    (clk),
        .RESET  (rst_n),
        .bus    (bus8),
        .STATE  (state8),
        .ZERO   (zero8),
        .CARRY  (carry8),
        .HALTED (halted8)
    );

    toy_cpu_gen2 #(.DATA_W(16), .ADDR_W(10), .RESET_PC(10'h000)) dutw (
        .CLK    (clk),
        .RESET  (rst_n),
        .bus    (busw),
        .STATE  (statew),
        .ZERO   (zerow),
        .CARRY  (carryw),
        .HALTED (haltedw)
    );

    // Synchronous memories; the load pulse copies the staged images in.
    logic [7:0]  mem8 [256];
    logic [7:0]  prog [256];
    logic [15:0] memw [1024];
    logic [15:0] progw [1024];
    int          wr_cnt = 0;

    always @(posedge clk) begin
        if (load) begin
            mem8 <= prog;
            memw <= progw;
        end else begin
            if (bus8.MEM_EN) begin
                if (bus8.RORW) bus8.D_IN <= mem8[bus8.ADDR];
                else begin
                    mem8[bus8.ADDR] <= bus8.D_OUT;
                    wr_cnt <= wr_cnt + 1;
                end
            end
            if (busw.MEM_EN) begin
                if (busw.RORW) busw.D_IN <= memw[busw.ADDR];
                else memw[busw.ADDR] <= busw.D_OUT;
            end
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int cyc, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- instruction-level model ----------------
    typedef struct packed {
        logic [7:0] st;
        logic       men;
        logic       rw;
        logic [7:0] addr;
        logic [7:0] dout;
        logic       z;
        logic       c;
        logic       halted;
    } cyc_t;

    cyc_t       exp_q[$];
    cyc_t       obs_q[$];
    logic [7:0] mmem [256];
    logic       m_z, m_c;
    logic [7:0] code[$];

    task automatic push(input logic [7:0] st, input logic men, input logic rw,
                        input logic [7:0] a, input logic [7:0] d);
        cyc_t r;
        r.st = st; r.men = men; r.rw = rw; r.addr = a; r.dout = d;
        r.z = m_z; r.c = m_c; r.halted = (st == 8'h80);
        exp_q.push_back(r);
    endtask

    function automatic bit has_operand(input logic [7:0] op);
        return (op inside {8'h01, 8'h02, 8'h04, 8'h08}) ||
               (BranchEn && (op inside {8'h10, 8'h20}));
    endfunction

    // Expands instructions into the per-cycle bus trace the rules require.
    task automatic build_model(input int n);
        logic [7:0] pc, acc, op, opnd, v, last;
        logic [8:0] sum;
        bit halted;
        pc = RstPc8; acc = 8'h00; m_z = 1'b1; m_c = 1'b0; last = pc; halted = 0;
        exp_q.delete();
        while (exp_q.size() < n) begin
            if (halted) begin
                push(8'h80, 1'b0, 1'b1, last, 8'h00);
                continue;
            end
            push(8'h01, 1'b1, 1'b1, pc, 8'h00);
            last = pc; op = mmem[pc]; pc = pc + 8'd1;
            push(8'h02, 1'b0, 1'b1, last, 8'h00);
            if (op == 8'h80) halted = 1;
            else if (has_operand(op)) begin
                push(8'h04, 1'b1, 1'b1, pc, 8'h00);
                last = pc; opnd = mmem[pc]; pc = pc + 8'd1;
                push(8'h08, 1'b0, 1'b1, last, 8'h00);
                case (op)
                    8'h01: begin acc = opnd; m_z = (acc == 8'h00); end
                    8'h10: pc = opnd;
                    8'h20: if (m_z) pc = opnd;
                    8'h02, 8'h04: begin
                        push(8'h10, 1'b1, 1'b1, opnd, 8'h00);
                        last = opnd;
                        push(8'h20, 1'b0, 1'b1, last, 8'h00);
                        v = mmem[opnd];
                        if (op == 8'h04) begin
                            sum = {1'b0, acc} + {1'b0, v};
                            acc = sum[7:0]; m_c = sum[8];
                        end else acc = v;
                        m_z = (acc == 8'h00);
                    end
                    8'h08: begin
                        push(8'h40, 1'b1, 1'b0, opnd, acc);
                        last = opnd; mmem[opnd] = acc;
                    end
                    default: ;
                endcase
            end
        end
        while (exp_q.size() > n) void'(exp_q.pop_back());
    endtask

    // ---------------- compare process ----------------
    cyc_t e_c, o_c;
    always @(negedge clk) begin
        if (cmp_en && exp_q.size() > 0) begin
            e_c = exp_q.pop_front();
            o_c.st = state8; o_c.men = bus8.MEM_EN; o_c.rw = bus8.RORW; o_c.addr = bus8.ADDR;
            o_c.dout = bus8.D_OUT; o_c.z = zero8; o_c.c = carry8; o_c.halted = halted8;
            obs_q.push_back(o_c);
            chk("STATE", obs_q.size() - 1, o_c.st, e_c.st);
            chk("STATE_onehot", obs_q.size() - 1, 32'($onehot(o_c.st)), 32'd1);
            chk("MEM_EN", obs_q.size() - 1, o_c.men, e_c.men);
            chk("ADDR", obs_q.size() - 1, o_c.addr, e_c.addr);
            chk("D_OUT", obs_q.size() - 1, o_c.dout, e_c.dout);
            chk("ZERO", obs_q.size() - 1, o_c.z, e_c.z);
            chk("CARRY", obs_q.size() - 1, o_c.c, e_c.c);
            chk("HALTED", obs_q.size() - 1, o_c.halted, e_c.halted);
            if (e_c.men) chk("RORW", obs_q.size() - 1, o_c.rw, e_c.rw);
        end
    end

    function automatic cyc_t obs(input int i);
        cyc_t r;
        r = '0;
        if (i < obs_q.size()) r = obs_q[i];
        return r;
    endfunction

    // ---------------- sequencing helpers ----------------
    task automatic place();
        prog = '{default: 8'h00};
        foreach (code[i]) prog[(int'(RstPc8) + i) % 256] = code[i];
    endtask

    task automatic load_mem();
        mmem = prog;
        @(posedge clk); #1 load = 1'b1;
        @(posedge clk); #1 load = 1'b0;
    endtask

    // Leaves the bench 1ns after the edge that first samples RESET high.
    task automatic reset_seq();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_STATE", -1, state8, 8'h01);
        chk("rst_MEM_EN", -1, bus8.MEM_EN, 1'b0);
        chk("rst_RORW", -1, bus8.RORW, 1'b1);
        chk("rst_ADDR", -1, bus8.ADDR, RstPc8);
        chk("rst_D_OUT", -1, bus8.D_OUT, 8'h00);
        chk("rst_HALTED", -1, halted8, 1'b0);
        chk("rst_ZERO", -1, zero8, 1'b1);
        chk("rst_CARRY", -1, carry8, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("release_MEM_EN", -1, bus8.MEM_EN, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic run_prog(input int n);
        load_mem();
        build_model(n);
        reset_seq();
        obs_q.delete();
        cmp_en = 1'b1;
        for (int k = 0; k < n + 4 && exp_q.size() > 0; k++) @(posedge clk);
        chk("trace_drained", n, exp_q.size(), 0);
        #1 cmp_en = 1'b0;
    endtask

    initial begin
        int wc;
        rst_n = 1'b0; load = 1'b0; cmp_en = 1'b0;

        // Wide part: LDI 0xFFFF (upper opcode bits ignored), ADD [0x100]=2, STA 0x200, HLT.
        progw = '{default: 16'h0000};
        progw[0] = 16'hAB01; progw[1] = 16'hFFFF; progw[2] = 16'h0004; progw[3] = 16'h0100;
        progw[4] = 16'h0008; progw[5] = 16'h0200; progw[6] = 16'h0080;
        progw[10'h100] = 16'h0002; progw[10'h200] = 16'h1234;

        // LDI 0xAA; HLT -> HALT at cycle 6.
        code = '{8'h01, 8'hAA, 8'h80};
        place();
        run_prog(10);
        chk("ldi_halt_c5", 5, obs(5).halted, 1'b0);
        chk("ldi_halt_c6", 6, obs(6).halted, 1'b1);
        chk("ldi_zero_c6", 6, obs(6).z, 1'b0);
        chk("wrap_opfetch_addr", 2, obs(2).addr, 8'h00);

        // LDI 0xFF; ADD [0x10]=1; STA 0x30; HLT.
        code = '{8'h01, 8'hFF, 8'h04, 8'h10, 8'h08, 8'h30, 8'h80};
        place();
        prog[8'h10] = 8'h01; prog[8'h30] = 8'h77;
        run_prog(20);
        chk("add_carry_before", 9, obs(9).c, 1'b0);
        chk("add_carry_after", 10, obs(10).c, 1'b1);
        chk("add_zero_after", 19, obs(19).z, 1'b1);
        chk("add_sta_mem", -1, mem8[8'h30], 8'h00);

        // LDI 0x5C; STA 0x20; HLT -> write in cycle 8.
        code = '{8'h01, 8'h5C, 8'h08, 8'h20, 8'h80};
        place();
        run_prog(12);
        chk("sta_state", 8, obs(8).st, 8'h40);
        chk("sta_men", 8, obs(8).men, 1'b1);
        chk("sta_rorw", 8, obs(8).rw, 1'b0);
        chk("sta_addr", 8, obs(8).addr, 8'h20);
        chk("sta_dout", 8, obs(8).dout, 8'h5C);
        chk("sta_mem", -1, mem8[8'h20], 8'h5C);

        // JZ 0x40 with Z=1 from reset.
        code = '{8'h20, 8'h40, 8'h80};
        place();
        prog[8'h40] = 8'h80;
        run_prog(10);
        if (BranchEn) begin
            chk("jz_taken_addr", 4, obs(4).addr, 8'h40);
            chk("jz_taken_state", 4, obs(4).st, 8'h01);
        end else begin
            chk("jz_nop_no_opfetch", 2, obs(2).st, 8'h01);
            chk("jz_nop_next_addr", 4, obs(4).addr, 8'h01);
        end

        // LDI 5 (Z=0); JZ 0x40 falls through to PC+2 = 0x03 either way.
        code = '{8'h01, 8'h05, 8'h20, 8'h40, 8'h80};
        place();
        prog[8'h40] = 8'h80;
        run_prog(12);
        chk("jz_fallthrough_addr", 8, obs(8).addr, 8'h03);

        // NOPs (0x00, 0x40); LDA [0x50]; ADD [0x51]; STA 0x52; JMP 0x60; HLT at 0x60.
        code = '{8'h00, 8'h40, 8'h02, 8'h50, 8'h04, 8'h51, 8'h08, 8'h52, 8'h10, 8'h60, 8'h80};
        place();
        prog[8'h50] = 8'h3C; prog[8'h51] = 8'h14; prog[8'h60] = 8'h80;
        run_prog(34);
        chk("lda_add_mem", -1, mem8[8'h52], 8'h50);

        // Reset asserted during OPLATCH of STA aborts the write.
        code = '{8'h01, 8'h5C, 8'h08, 8'h20, 8'h80};
        place();
        prog[8'h20] = 8'h11;
        load_mem();
        reset_seq();
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("abort_pre_state", 6, state8, 8'h04);
        wc = wr_cnt;
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        chk("abort_men_in_reset", 7, bus8.MEM_EN, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("abort_addr_resetpc", 8, bus8.ADDR, RstPc8);
        chk("abort_men_gap", 8, bus8.MEM_EN, 1'b0);
        @(negedge clk);
        chk("abort_refetch_addr", 9, bus8.ADDR, RstPc8);
        chk("abort_refetch_state", 9, state8, 8'h01);
        chk("abort_no_write", -1, wr_cnt - wc, 0);
        chk("abort_mem_kept", -1, mem8[8'h20], 8'h11);

        // Wide instance: give it time to finish its program.
        reset_seq();
        repeat (25) @(posedge clk);
        @(negedge clk);
        chk("wide_sum", -1, memw[10'h200], 16'h0001);
        chk("wide_carry", -1, carryw, 1'b1);
        chk("wide_zero", -1, zerow, 1'b0);
        chk("wide_halted", -1, haltedw, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
